// File: rtl/log_capture_engine.sv
// Trigger-based capture logger: packs two selected channels per kept sample into a circular
// BRAM buffer with a configurable pre-trigger history and a 1-cycle read-first read port.
module log_capture_engine #(
    parameter int N_CH      = 4,
    parameter int CH_WIDTH  = 12,
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 32768,
    parameter int DEC_WIDTH = 8,
    localparam int AW = $clog2(RAM_DEPTH),
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [N_CH*CH_WIDTH-1:0] i_ch_data,
    input  logic                     i_ch_valid,
    input  logic [SW-1:0]            i_sel_a,
    input  logic [SW-1:0]            i_sel_b,
    input  logic [DEC_WIDTH-1:0]     i_decim,
    input  logic                     i_trig_mode,
    input  logic [AW-1:0]            i_pre_len,
    input  logic                     i_arm,
    input  logic                     i_trig,
    input  logic                     i_rd_en,
    input  logic [AW-1:0]            i_rd_addr,
    output logic [RAM_WIDTH-1:0]     o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [AW-1:0]            o_trig_addr,
    output logic [AW-1:0]            o_start_addr
);

    localparam int HALF = RAM_WIDTH / 2;
    localparam int CW   = AW + 1;
    localparam logic [AW-1:0] LAST    = AW'(RAM_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t               state;
    logic [DEC_WIDTH-1:0] decim_q, dec_cnt;
    logic [SW-1:0]        sel_a_q, sel_b_q;
    logic                 trig_pend;
    logic [AW-1:0]        pre_q, wr_ptr, wr_ptr_next, pre_clamped, start_calc;
    logic [CW-1:0]        cnt, post_len;
    logic                 keep, we;
    logic [CH_WIDTH-1:0]  ch_a, ch_b;
    logic [RAM_WIDTH-1:0] wr_word;
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Out-of-range selects fall through to channel 0.
    always_comb begin
        ch_a = i_ch_data[CH_WIDTH-1:0];
        ch_b = i_ch_data[CH_WIDTH-1:0];
        for (int k = 1; k < N_CH; k++) begin
            if (sel_a_q == SW'(k)) ch_a = i_ch_data[k*CH_WIDTH +: CH_WIDTH];
            if (sel_b_q == SW'(k)) ch_b = i_ch_data[k*CH_WIDTH +: CH_WIDTH];
        end
        wr_word = {HALF'($signed(ch_a)), HALF'($signed(ch_b))};
    end

    always_comb begin
        keep        = i_ch_valid && (dec_cnt == '0);
        we          = keep && (state == S_PRE || state == S_WAIT || state == S_POST);
        wr_ptr_next = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        pre_clamped = (i_pre_len > LAST) ? LAST : i_pre_len;
        post_len    = DEPTH_C - CW'(pre_q);
        start_calc  = (wr_ptr >= pre_q) ? wr_ptr - pre_q
                                        : AW'(CW'(wr_ptr) + DEPTH_C - CW'(pre_q));
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            decim_q      <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            pre_q        <= '0;
            dec_cnt      <= '0;
            wr_ptr       <= '0;
            cnt          <= '0;
            trig_pend    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_trig_addr  <= '0;
            o_start_addr <= '0;
        end else begin
            if (i_ch_valid) dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DEC_WIDTH'(1);
            if (we) wr_ptr <= wr_ptr_next;
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_arm) begin
                        decim_q   <= i_decim;
                        sel_a_q   <= i_sel_a;
                        sel_b_q   <= i_sel_b;
                        pre_q     <= i_trig_mode ? pre_clamped : '0;
                        dec_cnt   <= '0;
                        wr_ptr    <= '0;
                        cnt       <= '0;
                        trig_pend <= 1'b0;
                        o_done    <= 1'b0;
                        o_busy    <= 1'b1;
                        if (!i_trig_mode)          state <= S_POST;
                        else if (pre_clamped == '0) state <= S_WAIT;
                        else                       state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (keep) begin
                        if (cnt + CW'(1) == CW'(pre_q)) begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                // A trigger on a non-kept cycle is remembered until the next kept sample.
                S_WAIT: begin
                    if (i_trig) trig_pend <= 1'b1;
                    if (keep && (trig_pend || i_trig)) begin
                        trig_pend    <= 1'b0;
                        o_trig_addr  <= wr_ptr;
                        o_start_addr <= start_calc;
                        cnt          <= CW'(1);
                        if (post_len == CW'(1)) begin
                            state  <= S_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (keep) begin
                        if (cnt == '0) begin
                            o_trig_addr  <= wr_ptr;
                            o_start_addr <= start_calc;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt + CW'(1) == post_len) begin
                            state  <= S_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_word;
    end

    // Nonblocking read of the array gives read-first behaviour on an address collision.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule
